// File: rtl/cdiv_pkg.sv
// ============================================================================
// Module      : cdiv_pkg
// Description : Shared constants, types and helpers for the cdiv_seq complex
//               divider (sign-magnitude component and complex-word formats).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cdiv_pkg;

  localparam int MAG_W    = 4;
  localparam int DIV_BITS = 2 * MAG_W + 1;
  localparam int W        = 2 * (MAG_W + 1);
  localparam int SW       = DIV_BITS + 2;

  typedef struct packed {
    logic             sign;
    logic [MAG_W-1:0] mag;
  } comp_t;

  typedef struct packed {
    comp_t re;
    comp_t im;
  } cword_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PREP   = 3'd1,
    ST_DIV_RE = 3'd2,
    ST_DIV_IM = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Negative zero collapses to 0 here because the magnitude drives the value.
  function automatic logic signed [SW-1:0] to_signed(comp_t c);
    logic signed [SW-1:0] m;
    m = $signed({{(SW-MAG_W){1'b0}}, c.mag});
    return c.sign ? -m : m;
  endfunction

  function automatic logic [DIV_BITS-1:0] abs_mag(logic signed [SW-1:0] v);
    logic signed [SW-1:0] t;
    t = v[SW-1] ? -v : v;
    return DIV_BITS'(t);
  endfunction

  function automatic comp_t make_comp(logic neg, logic [MAG_W-1:0] mag);
    comp_t r;
    r.sign = neg & (|mag);
    r.mag  = mag;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cdiv_iter_div.sv
// ============================================================================
// Module      : cdiv_iter_div
// Description : Iterative restoring divider, one quotient bit per step (MSB
//               first). mag reports the result after the current step.
//               Macro CDIV_ROUND_EN: round half away from zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cdiv_iter_div
  import cdiv_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                step,
  input  logic [DIV_BITS-1:0] num,
  input  logic [DIV_BITS-1:0] den,
  output logic [MAG_W-1:0]    mag
);

  logic [DIV_BITS-1:0] rem_q, rem_d;
  logic [DIV_BITS-1:0] quo_q, quo_d;
  logic [DIV_BITS:0]   shifted;
  logic                ge;
  logic [DIV_BITS-1:0] rem_nxt;
  logic [DIV_BITS-1:0] quo_nxt;

  always_comb begin
    shifted = {rem_q, quo_q[DIV_BITS-1]};
    ge      = shifted >= {1'b0, den};
    // When ge, shifted - den < den, so the low bits alone are exact.
    rem_nxt = ge ? (shifted[DIV_BITS-1:0] - den) : shifted[DIV_BITS-1:0];
    quo_nxt = {quo_q[DIV_BITS-2:0], ge};

    rem_d = rem_q;
    quo_d = quo_q;
    if (load) begin
      rem_d = '0;
      quo_d = num;
    end else if (step) begin
      rem_d = rem_nxt;
      quo_d = quo_nxt;
    end
  end

`ifdef CDIV_ROUND_EN
  logic round_up;
  always_comb begin
    round_up = {rem_nxt, 1'b0} >= {1'b0, den};
    mag      = quo_nxt[MAG_W-1:0] + {{(MAG_W-1){1'b0}}, round_up};
  end
`else
  always_comb begin
    mag = quo_nxt[MAG_W-1:0];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cdiv_seq.sv
// ============================================================================
// Module      : cdiv_seq
// Description : Sequential sign-magnitude complex divider q = z1 / z2 with a
//               start/done handshake; one shared divider serves re then im.
//               Macro CDIV_ROUND_EN: round half away from zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cdiv_seq
  import cdiv_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic         div_by_zero
);

  localparam logic [3:0] CNT_LAST = 4'(DIV_BITS - 1);

  state_t              state_q, state_d;
  cword_t              z1_q, z1_d, z2_q, z2_d;
  logic [DIV_BITS-1:0] den_q, den_d;
  logic [DIV_BITS-1:0] im_mag_q, im_mag_d;
  logic                re_neg_q, re_neg_d, im_neg_q, im_neg_d;
  logic                dz_q, dz_d;
  comp_t               re_q, re_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
  cword_t              quotient_q, quotient_d;

  logic signed [SW-1:0] num_re, num_im;
  logic [DIV_BITS-1:0]  den_c;
  logic                 div_load, div_step;
  logic [DIV_BITS-1:0]  div_num;
  logic [MAG_W-1:0]     div_mag;

  cdiv_iter_div u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (div_load),
    .step  (div_step),
    .num   (div_num),
    .den   (den_q),
    .mag   (div_mag)
  );

  always_comb begin
    num_re = to_signed(z1_q.re) * to_signed(z2_q.re) + to_signed(z1_q.im) * to_signed(z2_q.im);
    num_im = to_signed(z1_q.im) * to_signed(z2_q.re) - to_signed(z1_q.re) * to_signed(z2_q.im);
    den_c  = DIV_BITS'(z2_q.re.mag) * DIV_BITS'(z2_q.re.mag)
           + DIV_BITS'(z2_q.im.mag) * DIV_BITS'(z2_q.im.mag);

    state_d    = state_q;
    z1_d       = z1_q;
    z2_d       = z2_q;
    den_d      = den_q;
    im_mag_d   = im_mag_q;
    re_neg_d   = re_neg_q;
    im_neg_d   = im_neg_q;
    dz_d       = dz_q;
    re_d       = re_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    dbz_d      = dbz_q;
    quotient_d = quotient_q;
    div_load   = 1'b0;
    div_step   = 1'b0;
    div_num    = '0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          z1_d    = cword_t'(dividend);
          z2_d    = cword_t'(divisor);
          busy_d  = 1'b1;
          state_d = ST_PREP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PREP: begin
        den_d    = den_c;
        dz_d     = (den_c == '0);
        re_neg_d = num_re[SW-1];
        im_neg_d = num_im[SW-1];
        im_mag_d = abs_mag(num_im);
        div_load = 1'b1;
        div_num  = abs_mag(num_re);
        cnt_d    = '0;
        state_d  = ST_DIV_RE;
      end
      ST_DIV_RE: begin
        // A zero divisor leaves after a single DIV_RE cycle.
        if (dz_q) begin
          quotient_d = '0;
          dbz_d      = 1'b1;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          state_d    = ST_DONE;
        end else begin
          div_step = 1'b1;
          cnt_d    = cnt_q + 4'd1;
          if (cnt_q == CNT_LAST) begin
            re_d     = make_comp(re_neg_q, div_mag);
            div_load = 1'b1;
            div_num  = im_mag_q;
            cnt_d    = '0;
            state_d  = ST_DIV_IM;
          end
        end
      end
      ST_DIV_IM: begin
        div_step = 1'b1;
        cnt_d    = cnt_q + 4'd1;
        if (cnt_q == CNT_LAST) begin
          quotient_d = {re_q, make_comp(im_neg_q, div_mag)};
          dbz_d      = 1'b0;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          state_d    = ST_DONE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      z1_q       <= '0;
      z2_q       <= '0;
      den_q      <= '0;
      im_mag_q   <= '0;
      re_neg_q   <= 1'b0;
      im_neg_q   <= 1'b0;
      dz_q       <= 1'b0;
      re_q       <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
      quotient_q <= '0;
    end else begin
      state_q    <= state_d;
      z1_q       <= z1_d;
      z2_q       <= z2_d;
      den_q      <= den_d;
      im_mag_q   <= im_mag_d;
      re_neg_q   <= re_neg_d;
      im_neg_q   <= im_neg_d;
      dz_q       <= dz_d;
      re_q       <= re_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
      quotient_q <= quotient_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_cdiv_seq.sv
// ============================================================================
// Module      : tb_cdiv_seq
// Description : Scoreboard bench for cdiv_seq; expected results come from an
//               integer-arithmetic reference model. Honours CDIV_ROUND_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cdiv_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [9:0] dividend;
  logic [9:0] divisor;
  logic       busy;
  logic       done;
  logic [9:0] quotient;
  logic       div_by_zero;

  cdiv_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .div_by_zero (div_by_zero)
  );

  typedef struct {
    logic [9:0] q;
    logic       dz;
    int         due;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int smv(logic [4:0] x);
    return x[4] ? -int'(x[3:0]) : int'(x[3:0]);
  endfunction

  function automatic logic [4:0] comp(int n, int den);
    int an, m, r;
    an = (n < 0) ? -n : n;
    m  = an / den;
    r  = an % den;
`ifdef CDIV_ROUND_EN
    if (2 * r >= den) m++;
`endif
    return {(n < 0) && (m != 0), 4'(m)};
  endfunction

  task automatic model(input logic [9:0] dvd, input logic [9:0] dvs,
                       output logic [9:0] q, output logic dz, output int lat);
    int a, b, c, d, den;
    a = smv(dvd[9:5]); b = smv(dvd[4:0]);
    c = smv(dvs[9:5]); d = smv(dvs[4:0]);
    den = c * c + d * d;
    if (den == 0) begin
      q = '0; dz = 1'b1; lat = 2;
    end else begin
      q = {comp(a * c + b * d, den), comp(b * c - a * d, den)};
      dz = 1'b0; lat = 19;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("busy_timeout", 32'(busy), 32'd0);
  endtask

  task automatic issue(input logic [9:0] dvd, input logic [9:0] dvs,
                       input logic [9:0] eq, input logic edz, input int lat);
    exp_t e;
    wait_idle();
    start = 1'b1; dividend = dvd; divisor = dvs;
    e.q = eq; e.dz = edz; e.due = cyc + 1 + lat;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    dividend = 10'($urandom);
    divisor  = 10'($urandom);
  endtask

  task automatic issue_model(input logic [9:0] dvd, input logic [9:0] dvs);
    logic [9:0] q; logic dz; int lat;
    model(dvd, dvs, q, dz, lat);
    issue(dvd, dvs, q, dz, lat);
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("quotient", 32'(quotient), 32'(mon_e.q));
        chk("div_by_zero", 32'(div_by_zero), 32'(mon_e.dz));
        chk("done_cycle", 32'(cyc), 32'(mon_e.due));
      end
    end
  end

  initial begin
    logic [9:0] q; logic dz; int lat; int n;
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(10'b00011_00100, 10'b00001_00000, 10'b00011_00100, 1'b0, 19);
    issue(10'b01010_00101, 10'b00001_00010, 10'b00100_10011, 1'b0, 19);
    issue(10'b10110_00000, 10'b00000_00010, 10'b00000_00011, 1'b0, 19);
    issue(10'b00011_00100, 10'b00000_00000, 10'b00000_00000, 1'b1, 2);
    issue(10'b00011_00100, 10'b10000_10000, 10'b00000_00000, 1'b1, 2);
`ifdef CDIV_ROUND_EN
    issue(10'b00111_00000, 10'b00010_00000, 10'b00100_00000, 1'b0, 19);
    issue(10'b10111_00000, 10'b00010_00000, 10'b10100_00000, 1'b0, 19);
`else
    issue(10'b00111_00000, 10'b00010_00000, 10'b00011_00000, 1'b0, 19);
    issue(10'b10111_00000, 10'b00010_00000, 10'b10011_00000, 1'b0, 19);
`endif

    // start held high: accepted only at idle and in each DONE cycle
    wait_idle();
    start = 1'b1; dividend = 10'b01010_00101; divisor = 10'b00001_00010;
    model(dividend, divisor, q, dz, lat);
    for (int k = 0; k < 3; k++) begin
      wait_idle();
      exp_q.push_back('{q, dz, cyc + 1 + lat});
      @(negedge clk);
    end
    start = 1'b0;

    // reset during DIV_RE aborts the operation without a done
    issue(10'b00011_00100, 10'b00001_00000, 10'b00011_00100, 1'b0, 19);
    issue_model(10'b01111_01111, 10'b00001_10001);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_quotient", 32'(quotient), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("post_abort_quotient", 32'(quotient), 32'd0);
    chk("post_abort_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 40; i++) begin
      logic [9:0] dvs;
      dvs = 10'($urandom);
      if ($urandom_range(0, 7) == 0) dvs = {dvs[9], 4'd0, dvs[4], 4'd0};
      issue_model(10'($urandom), dvs);
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        if (busy) begin
          start = 1'b1; dividend = 10'($urandom); divisor = 10'($urandom);
          @(negedge clk);
          start = 1'b0;
        end
      end
    end

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
